// File: rtl/async_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : async_fifo_pkg
//  Purpose  : Shared types and helpers for the async FIFO write-side arbiter
//             and its round-robin picker.
//  Contents : arb_state_t - arbiter FSM state encoding (IDLE / LOCK)
//             src_w(n)    - width of a source index for n requesters (min 1)
//  Revision : 1.0 - initial release
// ============================================================================
package async_fifo_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } arb_state_t;

    // Width of an index able to address n requesters; never less than one
    // bit so that degenerate configurations still elaborate.
    function automatic int src_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : async_fifo_pkg
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
//  Module   : rr_pick
//  Purpose  : Combinational round-robin priority picker. Scans the request
//             vector upward from i_ptr, wrapping modulo NREQ, and returns the
//             first set request as both a one-hot grant and an index.
//  Ports    : i_req   [NREQ-1:0] request vector
//             i_ptr   [SRCW-1:0] highest-priority position (must be < NREQ)
//             o_grant [NREQ-1:0] one-hot grant (all zero when no request)
//             o_idx   [SRCW-1:0] index of the granted request
//             o_valid            at least one request is set
//  Revision : 1.0 - initial release
// ============================================================================
module rr_pick
    import async_fifo_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int SRCW = src_w(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [SRCW-1:0] i_ptr,
    output logic [NREQ-1:0] o_grant,
    output logic [SRCW-1:0] o_idx,
    output logic            o_valid
);

    // One extra bit so ptr + offset (at most 2*NREQ-2) never overflows
    // before the modulo correction.
    logic [SRCW:0]   w_sum;
    logic [SRCW-1:0] w_pos;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_sum   = '0;
        w_pos   = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_sum = {1'b0, i_ptr} + (SRCW+1)'(k);
            if (w_sum >= (SRCW+1)'(NREQ)) begin
                w_sum = w_sum - (SRCW+1)'(NREQ);
            end
            w_pos = w_sum[SRCW-1:0];
            if (!o_valid && i_req[w_pos]) begin
                o_valid        = 1'b1;
                o_grant[w_pos] = 1'b1;
                o_idx          = w_pos;
            end
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/async_fifo_wr_arb.sv
`default_nettype none
// ============================================================================
//  Module   : async_fifo_wr_arb
//  Purpose  : Shares one async FIFO write port among NREQ requesters with
//             packet-granular round-robin arbitration. A granted requester
//             holds the port until its last beat; every written word carries
//             the source index in its upper SRCW bits.
//  Ports    : wclk, wrst           write clock, async active-high reset
//             req_valid/req_last   per-requester beat valid / last-beat flag
//             req_data             payloads, requester i at [i*DSIZE +: DSIZE]
//             req_ready            per-requester accept (at most one set)
//             fifo_winc/fifo_wdata FIFO write strobe and {source, payload}
//             fifo_wfull/awfull    FIFO full / almost-full status
//             owner, locked        current packet owner, multi-beat lock flag
//  Revision : 1.0 - initial release
// ============================================================================
module async_fifo_wr_arb
    import async_fifo_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int DSIZE = 8,
    parameter int SRCW  = src_w(NREQ)
) (
    input  logic                   wclk,
    input  logic                   wrst,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ-1:0]        req_last,
    input  logic [NREQ*DSIZE-1:0]  req_data,
    output logic [NREQ-1:0]        req_ready,
    output logic                   fifo_winc,
    output logic [SRCW+DSIZE-1:0]  fifo_wdata,
    input  logic                   fifo_wfull,
    input  logic                   fifo_awfull,
    output logic [SRCW-1:0]        owner,
    output logic                   locked
);

    arb_state_t       r_state;
    arb_state_t       w_state_nxt;
    logic [SRCW-1:0]  r_owner;
    logic [SRCW-1:0]  w_owner_nxt;
    logic [SRCW-1:0]  r_rr_ptr;
    logic [SRCW-1:0]  w_rr_nxt;

    logic [NREQ-1:0]  w_pick_grant;
    logic [SRCW-1:0]  w_pick_idx;
    logic             w_pick_valid;
    logic [NREQ-1:0]  w_owner_oh;
    logic [SRCW-1:0]  w_sel;

    logic [DSIZE-1:0] w_data_arr [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign w_data_arr[gi] = req_data[gi*DSIZE +: DSIZE];
        end
    endgenerate

    rr_pick #(
        .NREQ (NREQ),
        .SRCW (SRCW)
    ) u_rr_pick (
        .i_req   (req_valid),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_pick_grant),
        .o_idx   (w_pick_idx),
        .o_valid (w_pick_valid)
    );

    always_comb begin
        w_owner_oh = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_owner_oh[i] = (SRCW'(i) == r_owner);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_rr_nxt    = r_rr_ptr;
        req_ready   = '0;
        fifo_winc   = 1'b0;
        w_sel       = '0;
        case (r_state)
            ST_IDLE: begin
                // New packets start only with headroom in the FIFO, so a
                // packet once started can always drain into it.
                if (w_pick_valid && !fifo_wfull && !fifo_awfull) begin
                    req_ready = w_pick_grant;
                    fifo_winc = 1'b1;
                    w_sel     = w_pick_idx;
                    w_rr_nxt  = (w_pick_idx == SRCW'(NREQ-1)) ? '0
                                                              : w_pick_idx + SRCW'(1);
                    if (!req_last[w_pick_idx]) begin
                        w_state_nxt = ST_LOCK;
                        w_owner_nxt = w_pick_idx;
                    end
                end
            end
            ST_LOCK: begin
                // Almost-full is ignored here; only a hard full stalls the
                // owner. A dropped owner valid is a bubble, not a release.
                if (!fifo_wfull) begin
                    req_ready = w_owner_oh;
                    if (req_valid[r_owner]) begin
                        fifo_winc = 1'b1;
                        w_sel     = r_owner;
                        if (req_last[r_owner]) begin
                            w_state_nxt = ST_IDLE;
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign fifo_wdata = fifo_winc ? {w_sel, w_data_arr[w_sel]} : '0;
    assign owner      = r_owner;
    assign locked     = (r_state == ST_LOCK);

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            r_state  <= ST_IDLE;
            r_owner  <= '0;
            r_rr_ptr <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_owner  <= w_owner_nxt;
            r_rr_ptr <= w_rr_nxt;
        end
    end

endmodule : async_fifo_wr_arb
`default_nettype wire

// File: tb/tb_async_fifo_wr_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_async_fifo_wr_arb
//  Purpose  : Self-checking bench for async_fifo_wr_arb (NREQ=4, DSIZE=8).
//             Expected FIFO words are queued as beats are offered and popped
//             whenever the arbiter strobes fifo_winc.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_async_fifo_wr_arb;

    localparam int NREQ  = 4;
    localparam int DSIZE = 8;
    localparam int SRCW  = 2;

    logic                  wclk = 1'b0;
    logic                  wrst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_last;
    logic [NREQ*DSIZE-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  fifo_winc;
    logic [SRCW+DSIZE-1:0] fifo_wdata;
    logic                  fifo_wfull;
    logic                  fifo_awfull;
    logic [SRCW-1:0]       owner;
    logic                  locked;

    async_fifo_wr_arb #(
        .NREQ  (NREQ),
        .DSIZE (DSIZE)
    ) dut (
        .wclk        (wclk),
        .wrst        (wrst),
        .req_valid   (req_valid),
        .req_last    (req_last),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .fifo_winc   (fifo_winc),
        .fifo_wdata  (fifo_wdata),
        .fifo_wfull  (fifo_wfull),
        .fifo_awfull (fifo_awfull),
        .owner       (owner),
        .locked      (locked)
    );

    always #5 wclk = ~wclk;

    logic [SRCW+DSIZE-1:0] sb_q [$];
    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic l, input logic [7:0] d);
        req_valid[i]           = v;
        req_last[i]            = l;
        req_data[i*DSIZE +: 8] = d;
    endtask

    task automatic push(input int tag, input logic [7:0] d);
        logic [1:0] t;
        t = tag[1:0];
        sb_q.push_back({t, d});
    endtask

    // One clock: sample at the falling edge, then advance to just past the
    // next rising edge where the next stimulus is applied.
    task automatic cyc(input logic ew, input logic el, input logic [3:0] er, input string nm);
        logic [SRCW+DSIZE-1:0] exp_w;
        @(negedge wclk);
        chk({nm, ":winc"},   32'(fifo_winc), 32'(ew));
        chk({nm, ":locked"}, 32'(locked),    32'(el));
        chk({nm, ":ready"},  32'(req_ready), 32'(er));
        chk({nm, ":wr_full"}, 32'(fifo_winc & fifo_wfull), 32'(0));
        if (fifo_winc === 1'b1) begin
            chk({nm, ":sb_nonempty"}, 32'(sb_q.size() > 0), 32'(1));
            if (sb_q.size() > 0) begin
                exp_w = sb_q.pop_front();
                chk({nm, ":wdata"}, 32'(fifo_wdata), 32'(exp_w));
            end
        end
        @(posedge wclk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int b;
        wrst        = 1'b1;
        req_valid   = '0;
        req_last    = '0;
        req_data    = '0;
        fifo_wfull  = 1'b0;
        fifo_awfull = 1'b0;
        repeat (2) @(posedge wclk);
        #1;

        // Reset state
        chk("rst:locked", 32'(locked),     32'(0));
        chk("rst:owner",  32'(owner),      32'(0));
        chk("rst:winc",   32'(fifo_winc),  32'(0));
        chk("rst:ready",  32'(req_ready),  32'(0));
        chk("rst:wdata",  32'(fifo_wdata), 32'(0));
        wrst = 1'b0;

        // Fairness: four single-beat streams, grant order 0,1,2,3,0,...
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, 1'b1, 8'hA0 + 8'(i));
        for (int k = 0; k < 8; k++) begin
            push(k % 4, 8'hA0 + 8'(k % 4));
            cyc(1'b1, 1'b0, 4'(1 << (k % 4)), "fair");
        end
        req_valid = '0;

        // Packet lock: move pointer to 2, then a 3-beat packet from 2
        set_req(1, 1'b1, 1'b1, 8'h11);
        push(1, 8'h11);
        cyc(1'b1, 1'b0, 4'b0010, "pre_lock");
        set_req(1, 1'b1, 1'b1, 8'h12);
        set_req(0, 1'b1, 1'b1, 8'h01);
        set_req(2, 1'b1, 1'b0, 8'h20);
        push(2, 8'h20);
        cyc(1'b1, 1'b0, 4'b0100, "lock_b0");
        chk("lock:owner", 32'(owner), 32'(2));
        set_req(2, 1'b1, 1'b0, 8'h21);
        push(2, 8'h21);
        cyc(1'b1, 1'b1, 4'b0100, "lock_b1");
        set_req(2, 1'b1, 1'b1, 8'h22);
        push(2, 8'h22);
        cyc(1'b1, 1'b1, 4'b0100, "lock_b2");
        req_valid = '0;
        cyc(1'b0, 1'b0, 4'b0000, "lock_gap");
        set_req(0, 1'b1, 1'b1, 8'h02);
        set_req(1, 1'b1, 1'b1, 8'h13);
        push(0, 8'h02);
        cyc(1'b1, 1'b0, 4'b0001, "lock_skip3");
        req_valid = '0;

        // awfull gating: blocks new packets only
        fifo_awfull = 1'b1;
        set_req(1, 1'b1, 1'b0, 8'h30);
        set_req(3, 1'b1, 1'b1, 8'h3F);
        cyc(1'b0, 1'b0, 4'b0000, "awf_idle0");
        cyc(1'b0, 1'b0, 4'b0000, "awf_idle1");
        fifo_awfull = 1'b0;
        push(1, 8'h30);
        cyc(1'b1, 1'b0, 4'b0010, "awf_b0");
        fifo_awfull = 1'b1;
        set_req(1, 1'b1, 1'b0, 8'h31);
        push(1, 8'h31);
        cyc(1'b1, 1'b1, 4'b0010, "awf_b1");
        set_req(1, 1'b1, 1'b1, 8'h32);
        push(1, 8'h32);
        cyc(1'b1, 1'b1, 4'b0010, "awf_b2");
        set_req(1, 1'b0, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 4'b0000, "awf_hold0");
        cyc(1'b0, 1'b0, 4'b0000, "awf_hold1");
        fifo_awfull = 1'b0;
        push(3, 8'h3F);
        cyc(1'b1, 1'b0, 4'b1000, "awf_rel");
        req_valid = '0;

        // wfull stall during a 4-beat packet from requester 0
        fifo_wfull = 1'b1;
        set_req(0, 1'b1, 1'b0, 8'h40);
        set_req(2, 1'b1, 1'b1, 8'h5A);
        cyc(1'b0, 1'b0, 4'b0000, "full_idle");
        b = 0;
        for (int c = 0; c < 7; c++) begin
            fifo_wfull = (c % 2) != 0;
            set_req(0, 1'b1, (b == 3), 8'h40 + 8'(b));
            if (!fifo_wfull) begin
                push(0, 8'h40 + 8'(b));
                cyc(1'b1, (c != 0), 4'b0001, "full_beat");
                b++;
            end else begin
                cyc(1'b0, 1'b1, 4'b0000, "full_stall");
            end
        end
        fifo_wfull = 1'b0;
        set_req(0, 1'b0, 1'b0, 8'h00);
        push(2, 8'h5A);
        cyc(1'b1, 1'b0, 4'b0100, "full_next");
        req_valid = '0;

        // Owner bubble: requester 3 drops valid for 5 cycles mid-packet
        set_req(3, 1'b1, 1'b0, 8'h60);
        set_req(0, 1'b1, 1'b1, 8'h07);
        push(3, 8'h60);
        cyc(1'b1, 1'b0, 4'b1000, "bub_b0");
        chk("bub:owner", 32'(owner), 32'(3));
        set_req(3, 1'b0, 1'b0, 8'h00);
        set_req(1, 1'b1, 1'b1, 8'h17);
        for (int c = 0; c < 5; c++) cyc(1'b0, 1'b1, 4'b1000, "bubble");
        set_req(3, 1'b1, 1'b0, 8'h61);
        push(3, 8'h61);
        cyc(1'b1, 1'b1, 4'b1000, "bub_b1");
        set_req(3, 1'b1, 1'b1, 8'h62);
        push(3, 8'h62);
        cyc(1'b1, 1'b1, 4'b1000, "bub_b2");
        req_valid = '0;
        cyc(1'b0, 1'b0, 4'b0000, "bub_end");

        // Reset mid-packet
        set_req(1, 1'b1, 1'b1, 8'h71);
        push(1, 8'h71);
        cyc(1'b1, 1'b0, 4'b0010, "rst_pre");
        set_req(1, 1'b0, 1'b0, 8'h00);
        set_req(2, 1'b1, 1'b0, 8'h80);
        set_req(3, 1'b1, 1'b1, 8'h90);
        push(2, 8'h80);
        cyc(1'b1, 1'b0, 4'b0100, "rst_b0");
        chk("rst_mid:locked_before", 32'(locked), 32'(1));
        #2;
        wrst      = 1'b1;
        req_valid = '0;
        #1;
        chk("rst_mid:locked", 32'(locked), 32'(0));
        chk("rst_mid:owner",  32'(owner),  32'(0));
        @(posedge wclk);
        #1;
        wrst = 1'b0;
        set_req(1, 1'b1, 1'b1, 8'h72);
        set_req(2, 1'b1, 1'b1, 8'h81);
        set_req(3, 1'b1, 1'b1, 8'h91);
        push(1, 8'h72);
        cyc(1'b1, 1'b0, 4'b0010, "post_rst");
        req_valid = '0;
        cyc(1'b0, 1'b0, 4'b0000, "end_idle");

        chk("sb_drained", 32'(sb_q.size()), 32'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule : tb_async_fifo_wr_arb
`default_nettype wire
